// File: rtl/cordic_phase_sweep.sv
// cordic_phase_sweep
//   Generates a stepped sequence of phase words for the CORDIC core's theta
//   input. The sequence is start, start+step, start+2*step, ... and each point
//   is held for max(hold,1) cycles. A sweep is either one-shot (count points)
//   or continuous, and it can be aborted with stop.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   start, stop  : control pulses (stop wins if both are high)
//   mode_cont    : 0 = one-shot, 1 = continuous (latched at start)
//   cfg_start    : first phase value (latched at start)
//   cfg_step     : two's-complement phase increment (latched at start)
//   cfg_hold     : cycles per point, 0 behaves as 1 (latched at start)
//   cfg_count    : points per sweep (latched at start)
//   theta        : current phase word
//   theta_valid  : pulse in the first cycle of each new point
//   point_idx    : index of the current point
//   busy         : high while a sweep is running
//   done         : pulse when a one-shot sweep completes normally
module cordic_phase_sweep #(
  parameter int W      = 16,
  parameter int HOLD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode_cont,
  input  logic [W-1:0]      cfg_start,
  input  logic [W-1:0]      cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic [W-1:0]      theta,
  output logic              theta_valid,
  output logic [CNT_W-1:0]  point_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_reg, state_next;

  logic [W-1:0]      theta_reg, theta_next;
  logic [W-1:0]      step_reg, step_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [HOLD_W-1:0] hold_rld_reg, hold_rld_next;
  logic [CNT_W-1:0]  idx_reg, idx_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              mode_reg, mode_next;
  logic              valid_reg, valid_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  // Reload value for the hold counter: a point lasts reload+1 cycles, so a
  // programmed hold of 0 collapses onto the hold=1 behaviour.
  logic [HOLD_W-1:0] cfg_rld;
  logic [CNT_W-1:0]  count_m1;
  logic              last_point;

  assign cfg_rld    = (cfg_hold == '0) ? '0 : cfg_hold - 1'b1;
  assign count_m1   = count_reg - 1'b1;
  assign last_point = (idx_reg == count_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      theta_reg    <= '0;
      step_reg     <= '0;
      hold_cnt_reg <= '0;
      hold_rld_reg <= '0;
      idx_reg      <= '0;
      count_reg    <= '0;
      mode_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      theta_reg    <= theta_next;
      step_reg     <= step_next;
      hold_cnt_reg <= hold_cnt_next;
      hold_rld_reg <= hold_rld_next;
      idx_reg      <= idx_next;
      count_reg    <= count_next;
      mode_reg     <= mode_next;
      valid_reg    <= valid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    theta_next    = theta_reg;
    step_next     = step_reg;
    hold_cnt_next = hold_cnt_reg;
    hold_rld_next = hold_rld_reg;
    idx_next      = idx_reg;
    count_next    = count_reg;
    mode_next     = mode_reg;
    busy_next     = busy_reg;
    valid_next    = 1'b0;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          if ((cfg_count != '0) || mode_cont) begin
            step_next     = cfg_step;
            hold_rld_next = cfg_rld;
            count_next    = cfg_count;
            mode_next     = mode_cont;
            theta_next    = cfg_start;
            valid_next    = 1'b1;
            idx_next      = '0;
            hold_cnt_next = cfg_rld;
            busy_next     = 1'b1;
            state_next    = RUN;
          end else begin
            // Empty one-shot sweep: completes immediately with no points.
            done_next = 1'b1;
          end
        end
      end

      RUN: begin
        if (stop) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (hold_cnt_reg != '0) begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end else if (!mode_reg && last_point) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          theta_next    = theta_reg + step_reg;
          valid_next    = 1'b1;
          hold_cnt_next = hold_rld_reg;
          // Continuous sweeps wrap the index at count; count=0 lets it run
          // through the full counter range.
          if (mode_reg && (count_reg != '0) && last_point)
            idx_next = '0;
          else
            idx_next = idx_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign theta       = theta_reg;
  assign theta_valid = valid_reg;
  assign point_idx   = idx_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_cordic_phase_sweep.sv
// Testbench for cordic_phase_sweep. Expected points (theta, index, cycle of
// appearance) and expected done cycles are queued when a sweep is launched;
// a negedge monitor pops and compares whenever theta_valid or done is seen.
module tb_cordic_phase_sweep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode_cont = 1'b0;
  logic [15:0] cfg_start = '0;
  logic [15:0] cfg_step = '0;
  logic [15:0] cfg_hold = '0;
  logic [15:0] cfg_count = '0;
  logic [15:0] theta;
  logic        theta_valid;
  logic [15:0] point_idx;
  logic        busy;
  logic        done;

  cordic_phase_sweep #(.W(16), .HOLD_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
    .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_hold(cfg_hold),
    .cfg_count(cfg_count), .theta(theta), .theta_valid(theta_valid),
    .point_idx(point_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] th;
    logic [15:0] idx;
    int          cyc;
  } point_t;

  point_t exp_q[$];
  int     done_q[$];
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: one line per observed transaction.
  always @(negedge clk) begin
    if (!rst) begin
      if (theta_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          point_t e;
          e = exp_q.pop_front();
          $display("point cyc=%0d theta=%04h idx=%0d", cyc, theta, point_idx);
          chk("theta", theta, e.th);
          chk("point_idx", point_idx, e.idx);
          chk("valid_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          int dc;
          dc = done_q.pop_front();
          $display("done  cyc=%0d theta=%04h idx=%0d", cyc, theta, point_idx);
          chk("done_cycle", cyc, dc);
        end
      end
    end
  end

  // Reference model: point k of a sweep is start + k*step (mod 2^16) and it
  // appears k*max(hold,1) cycles after the first point, which itself is
  // visible in the cycle right after the start edge.
  task automatic launch(input bit m, input logic [15:0] s, input logic [15:0] st,
                        input logic [15:0] h, input logic [15:0] n, input int npts);
    int c, hh, pts;
    point_t p;
    mode_cont = m; cfg_start = s; cfg_step = st; cfg_hold = h; cfg_count = n;
    start = 1'b1;
    c = cyc;
    hh = (h == 0) ? 1 : int'(h);
    pts = m ? npts : int'(n);
    $display("start mode=%0d start=%04h step=%04h hold=%0d count=%0d", m, s, st, h, n);
    for (int k = 0; k < pts; k++) begin
      p.th  = 16'((int'(s) + k * int'(st)) % 65536);
      p.idx = (m && n != 0) ? 16'(k % int'(n)) : 16'(k);
      p.cyc = c + 1 + k * hh;
      exp_q.push_back(p);
    end
    if (!m) done_q.push_back(c + 1 + int'(n) * hh);
    @(negedge clk);
    start = 1'b0;
    // Scramble config while running: must be ignored until the next start.
    mode_cont = 1'($urandom); cfg_start = 16'($urandom); cfg_step = 16'($urandom);
    cfg_hold = 16'($urandom_range(0, 9)); cfg_count = 16'($urandom_range(0, 9));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (!busy && exp_q.size() == 0 && done_q.size() == 0) break;
    end
    chk("drain", (!busy && exp_q.size() == 0 && done_q.size() == 0), 1);
  endtask

  task automatic cont_run(input logic [15:0] s, input logic [15:0] st,
                          input logic [15:0] h, input logic [15:0] n, input int npts);
    logic [15:0] th_last, idx_last;
    th_last  = 16'((int'(s) + (npts - 1) * int'(st)) % 65536);
    idx_last = (n != 0) ? 16'((npts - 1) % int'(n)) : 16'(npts - 1);
    launch(1'b1, s, st, h, n, npts);
    #1;
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("cont_points_seen", exp_q.size(), 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_valid", theta_valid, 0);
    chk("stop_theta", theta, th_last);
    chk("stop_idx", point_idx, idx_last);
    repeat (5) @(negedge clk);
    chk("frozen_theta", theta, th_last);
    chk("frozen_busy", busy, 0);
  endtask

  initial begin
    logic [15:0] th;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_theta", theta, 0);
    chk("rst_valid", theta_valid, 0);
    chk("rst_idx", point_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic one-shot sweep.
    launch(1'b0, 16'd20, 16'd200, 16'd20, 16'd4, 0);
    chk("busy_running", busy, 1);
    wait_idle();
    chk("final_theta", theta, 16'd620);
    chk("final_busy", busy, 0);

    // Upward and downward wrap.
    launch(1'b0, 16'hFF00, 16'h0100, 16'd1, 16'd3, 0);
    wait_idle();
    launch(1'b0, 16'h0001, 16'hFFFF, 16'd1, 16'd3, 0);
    wait_idle();

    // hold=0 behaves like hold=1.
    launch(1'b0, 16'h1234, 16'h0011, 16'd0, 16'd4, 0);
    wait_idle();

    // Empty one-shot sweep.
    th = theta;
    launch(1'b0, 16'h5555, 16'd1, 16'd3, 16'd0, 0);
    wait_idle();
    chk("empty_theta", theta, th);

    // Continuous sweep stopped after 10 points.
    cont_run(16'd0, 16'd10, 16'd3, 16'd2, 10);

    // start and stop together: nothing happens.
    th = theta;
    mode_cont = 1'b0; cfg_start = 16'h7777; cfg_count = 16'd5; cfg_hold = 16'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_valid", theta_valid, 0);
    chk("ss_done", done, 0);
    chk("ss_theta", theta, th);
    repeat (4) @(negedge clk);

    // Restart in the done cycle.
    launch(1'b0, 16'd100, 16'd5, 16'd2, 16'd2, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("restart_done_seen", seen, 1);
    launch(1'b0, 16'd900, 16'd3, 16'd2, 16'd3, 0);
    wait_idle();

    // Reset mid-sweep.
    launch(1'b0, 16'd1234, 16'd77, 16'd3, 16'd5, 0);
    repeat (6) @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    chk("mid_rst_theta", theta, 0);
    chk("mid_rst_valid", theta_valid, 0);
    chk("mid_rst_idx", point_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Randomized sweeps.
    for (int r = 0; r < 10; r++) begin
      launch(1'b0, 16'($urandom), 16'($urandom), 16'($urandom_range(0, 4)),
             16'($urandom_range(0, 6)), 0);
      wait_idle();
    end
    for (int r = 0; r < 4; r++) begin
      cont_run(16'($urandom), 16'($urandom), 16'($urandom_range(0, 3)),
               16'($urandom_range(0, 3)), int'($urandom_range(1, 8)));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
